alu_pipe: RTL

- Parametrised, handshaked successor to the combinational integer ALU.
- Accepts one operation per cycle through a valid/ready input port and registers result plus flags into a single output stage.
- Adds signed/unsigned compare, arithmetic shift, per-op flag generation, illegal-op reporting, a pass-through tag and an optional iterative multiplier.
- Sits between operand fetch and writeback in the execute path.

---
 rtl/alu_pipe_pkg.sv | 30 +++
 rtl/alu_pipe_mul_iter.sv | 64 ++++++
 rtl/alu_pipe.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: op codes, flag bit positions
// and the execute FSM state encoding.
package alu_pipe_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    localparam int FLAG_Z     = 0;
    localparam int FLAG_N     = 1;
    localparam int FLAG_C     = 2;
    localparam int FLAG_V     = 3;
    localparam int FLAG_ILL   = 4;
    localparam int FLAG_WIDTH = 5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_MUL      = 2'b01,
        S_MUL_WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
// After start, DATA_WIDTH steps run; done pulses for one cycle once the
// product is complete and busy drops. The product registers then hold
// their value until the next start so a stalled consumer can still read it.
module alu_pipe_mul_iter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] prod_hi,
    output logic [DATA_WIDTH-1:0] prod_lo
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [2*DATA_WIDTH-1:0] acc_r;
    logic [2*DATA_WIDTH-1:0] mcand_r;
    logic [DATA_WIDTH-1:0]   mplier_r;
    logic [CNT_W-1:0]        count_r;
    logic                    busy_r;

    assign busy    = busy_r;
    assign done    = busy_r && (count_r == CNT_LAST);
    assign prod_hi = acc_r[2*DATA_WIDTH-1:DATA_WIDTH];
    assign prod_lo = acc_r[DATA_WIDTH-1:0];

    // Load operands on start, then add one shifted partial product per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= {(2*DATA_WIDTH){1'b0}};
            mcand_r  <= {(2*DATA_WIDTH){1'b0}};
            mplier_r <= {DATA_WIDTH{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= {(2*DATA_WIDTH){1'b0}};
            mcand_r  <= {{DATA_WIDTH{1'b0}}, op_a};
            mplier_r <= op_b;
            count_r  <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
        end else if (done) begin
            busy_r   <= 1'b0;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= {mcand_r[2*DATA_WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[DATA_WIDTH-1:1]};
            count_r  <= count_r + CNT_ONE;
        end else begin
            busy_r   <= busy_r;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked integer ALU with a single registered output stage.
// Single-cycle ops appear on the output the edge after acceptance; the
// output register reloads on the same edge it drains, giving one result
// per cycle. Optional build macro ALU_PIPE_MUL_EN adds an iterative
// multiplier for op 10; without it op 10 is reported as illegal.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic [3:0]            in_ALU_Op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            out_ALU_flag,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]  out_data_r;
    logic [4:0]             out_flag_r;
    logic [TAG_WIDTH-1:0]   out_tag_r;
    logic                   out_valid_r;

    state_t                 state_s;
    logic                   accept_s;
    logic                   can_load_s;

    logic [SHAMT_WIDTH-1:0] shamt_s;
    logic [DATA_WIDTH:0]    sum_s;
    logic [DATA_WIDTH:0]    diff_s;
    logic [DATA_WIDTH-1:0]  alu_data_s;
    logic [4:0]             alu_flag_s;
    logic                   alu_c_s;
    logic                   alu_v_s;
    logic                   alu_ill_s;

    logic                   load_s;
    logic [DATA_WIDTH-1:0]  load_data_s;
    logic [4:0]             load_flag_s;
    logic [TAG_WIDTH-1:0]   load_tag_s;

    assign can_load_s = !out_valid_r || in_ready;
    assign out_ready  = (state_s == S_IDLE) && can_load_s;
    assign accept_s   = in_valid && out_ready;

    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_ALU_flag = out_flag_r;
    assign out_tag      = out_tag_r;

    assign shamt_s = in_B[SHAMT_WIDTH-1:0];
    assign sum_s   = {1'b0, in_A} + {1'b0, in_B};
    assign diff_s  = {1'b0, in_A} - {1'b0, in_B};

    // Single-cycle result and flags for the op currently offered.
    always_comb begin
        alu_data_s = {DATA_WIDTH{1'b0}};
        alu_c_s    = 1'b0;
        alu_v_s    = 1'b0;
        alu_ill_s  = 1'b0;
        case (in_ALU_Op)
            OP_ADD: begin
                alu_data_s = sum_s[DATA_WIDTH-1:0];
                alu_c_s    = sum_s[DATA_WIDTH];
                alu_v_s    = (in_A[DATA_WIDTH-1] == in_B[DATA_WIDTH-1]) &&
                             (sum_s[DATA_WIDTH-1] != in_A[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the zero-extended difference is the borrow.
                alu_data_s = diff_s[DATA_WIDTH-1:0];
                alu_c_s    = diff_s[DATA_WIDTH];
                alu_v_s    = (in_A[DATA_WIDTH-1] != in_B[DATA_WIDTH-1]) &&
                             (diff_s[DATA_WIDTH-1] != in_A[DATA_WIDTH-1]);
            end
            OP_AND:  alu_data_s = in_A & in_B;
            OP_OR:   alu_data_s = in_A | in_B;
            OP_XOR:  alu_data_s = in_A ^ in_B;
            OP_SLL:  alu_data_s = in_A << shamt_s;
            OP_SRL:  alu_data_s = in_A >> shamt_s;
            OP_SRA:  alu_data_s = $unsigned($signed(in_A) >>> shamt_s);
            OP_SLT:  alu_data_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_A) < $signed(in_B))};
            OP_SLTU: alu_data_s = {{(DATA_WIDTH-1){1'b0}}, (in_A < in_B)};
`ifdef ALU_PIPE_MUL_EN
            // Handled by the iterative multiplier; this path is never loaded.
            OP_MUL:  alu_data_s = {DATA_WIDTH{1'b0}};
`endif
            default: alu_ill_s = 1'b1;
        endcase
        alu_flag_s           = 5'b00000;
        alu_flag_s[FLAG_Z]   = !alu_ill_s && (alu_data_s == {DATA_WIDTH{1'b0}});
        alu_flag_s[FLAG_N]   = !alu_ill_s && alu_data_s[DATA_WIDTH-1];
        alu_flag_s[FLAG_C]   = alu_c_s;
        alu_flag_s[FLAG_V]   = alu_v_s;
        alu_flag_s[FLAG_ILL] = alu_ill_s;
    end

`ifdef ALU_PIPE_MUL_EN
    state_t                state_r;
    state_t                state_next_s;
    logic                  mul_start_s;
    logic                  mul_busy_s;
    logic                  mul_done_s;
    logic [DATA_WIDTH-1:0] mul_hi_s;
    logic [DATA_WIDTH-1:0] mul_lo_s;
    logic [4:0]            mul_flag_s;
    logic [TAG_WIDTH-1:0]  mul_tag_r;

    assign state_s = state_r;

    alu_pipe_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .start   (mul_start_s),
        .op_a    (in_A),
        .op_b    (in_B),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .prod_hi (mul_hi_s),
        .prod_lo (mul_lo_s)
    );

    // Flags for a completed product: carry/overflow mean the high half is lost.
    always_comb begin
        mul_flag_s           = 5'b00000;
        mul_flag_s[FLAG_Z]   = (mul_lo_s == {DATA_WIDTH{1'b0}});
        mul_flag_s[FLAG_N]   = mul_lo_s[DATA_WIDTH-1];
        mul_flag_s[FLAG_C]   = (mul_hi_s != {DATA_WIDTH{1'b0}});
        mul_flag_s[FLAG_V]   = (mul_hi_s != {DATA_WIDTH{1'b0}});
        mul_flag_s[FLAG_ILL] = 1'b0;
    end

    // Execute FSM state register.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: a multiply occupies the block until its product is loaded.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && (in_ALU_Op == OP_MUL)) begin
                    state_next_s = S_MUL;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_done_s && can_load_s) begin
                    state_next_s = S_IDLE;
                end else if (mul_done_s) begin
                    state_next_s = S_MUL_WAIT;
                end else begin
                    state_next_s = S_MUL;
                end
            end
            S_MUL_WAIT: begin
                if (can_load_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_MUL_WAIT;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM outputs: start the multiplier or select what the output stage loads.
    always_comb begin
        mul_start_s = 1'b0;
        load_s      = 1'b0;
        load_data_s = alu_data_s;
        load_flag_s = alu_flag_s;
        load_tag_s  = in_tag;
        case (state_r)
            S_IDLE: begin
                if (accept_s && (in_ALU_Op == OP_MUL)) begin
                    mul_start_s = 1'b1;
                end else if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            S_MUL, S_MUL_WAIT: begin
                load_data_s = mul_lo_s;
                load_flag_s = mul_flag_s;
                load_tag_s  = mul_tag_r;
                if (can_load_s && (mul_done_s || (state_r == S_MUL_WAIT))) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s      = 1'b0;
                mul_start_s = 1'b0;
            end
        endcase
    end

    // Hold the tag of the multiply in flight until its product is loaded.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            mul_tag_r <= {TAG_WIDTH{1'b0}};
        end else if (mul_start_s && !mul_busy_s) begin
            mul_tag_r <= in_tag;
        end else begin
            mul_tag_r <= mul_tag_r;
        end
    end
`else
    assign state_s = S_IDLE;

    // Every accepted op loads the output stage directly.
    always_comb begin
        load_s      = accept_s;
        load_data_s = alu_data_s;
        load_flag_s = alu_flag_s;
        load_tag_s  = in_tag;
    end
`endif

    // Output stage: reload on accept, clear on a drain without reload, else hold.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_flag_r  <= 5'b00000;
            out_tag_r   <= {TAG_WIDTH{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= load_data_s;
            out_flag_r  <= load_flag_s;
            out_tag_r   <= load_tag_s;
        end else if (out_valid_r && in_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule
